// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver with 16x oversampling.
//
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, one stop
// bit (1). The line is sampled at the middle of each bit. The byte and its
// error flags are committed together at the mid-stop-bit sample point.
//
// Parameters:
//   CLK_DIV0  clock cycles per 16x oversample tick at BaudSel = 0
//
// Ports:
//   Clock      system clock, rising edge
//   Rst        asynchronous active-high reset
//   rx         serial input, idle high, asynchronous to Clock
//   BaudSel    tick period = CLK_DIV0 >> BaudSel (minimum 1 clock)
//   ParEn      1 = parity bit follows the data bits
//   ParOdd     0 = even parity, 1 = odd parity
//   Ack        consumer acknowledge, clears Ready (and Overrun)
//   Dout       last received byte
//   Ready      Dout valid and not yet acknowledged
//   ParErr     parity mismatch on the byte in Dout
//   FrameErr   stop bit sampled low on the byte in Dout
//   Overrun    a frame completed while Ready was still 1 (sticky until Ack)
//   busy       receiver not in IDLE
//   dbg_state  current FSM state (debug visibility)
//
// Handshake: Ready rises on the commit edge and stays high until the edge
// after a cycle with Ack = 1. Ack while Ready = 0 is ignored. If a commit and
// an Ack land on the same cycle, the commit wins: Ready stays 1 with the new
// byte and Overrun is 0.

module uart_rx #(
  parameter int CLK_DIV0 = 326
) (
  input  logic       Clock,
  input  logic       Rst,
  input  logic       rx,
  input  logic [2:0] BaudSel,
  input  logic       ParEn,
  input  logic       ParOdd,
  input  logic       Ack,
  output logic [7:0] Dout,
  output logic       Ready,
  output logic       ParErr,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int PW = $clog2(CLK_DIV0 + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_n;

  logic          rx_meta, rxs;
  logic [PW-1:0] div_cnt;
  logic [PW-1:0] period_raw, period;
  logic          tick;
  logic [3:0]    scnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          perr;
  logic          armed;
  logic [2:0]    cfg_baud;
  logic          cfg_par, cfg_odd;

  logic          start_det, mid_start, bit_sample, commit;

  // Two-flop synchronizer; idle level is 1 so reset to 1.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Tick period from the latched baud select, clamped to at least 1 clock.
  always_comb begin
    period_raw = PW'(CLK_DIV0 >> cfg_baud);
    period     = (period_raw == '0) ? PW'(1) : period_raw;
  end

  assign tick       = (div_cnt >= (period - PW'(1)));
  assign mid_start  = tick && (scnt == 4'd7);
  assign bit_sample = tick && (scnt == 4'd15);

  // Next-state logic.
  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        // armed blocks a held-low line (break) from retriggering.
        if (armed && !rxs) begin
          start_det = 1'b1;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (mid_start) begin
          state_n = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_sample && (bit_idx == 3'd7)) begin
          state_n = cfg_par ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_sample) begin
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_sample) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Divider restarts on start detection so tick phase follows the start edge.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PW'(1);
    end
  end

  // Bit timing: scnt is re-zeroed at mid-start so every later sample falls
  // at scnt = 15, i.e. 16 ticks after the previous mid-bit point.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      scnt    <= '0;
      bit_idx <= '0;
    end else if (start_det) begin
      scnt    <= '0;
      bit_idx <= '0;
    end else begin
      if (state == S_START && mid_start) begin
        scnt <= '0;
      end else if (state != S_IDLE && tick) begin
        scnt <= scnt + 4'd1;
      end
      if (state == S_DATA && bit_sample) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Frame configuration and data/parity capture.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      cfg_baud <= '0;
      cfg_par  <= 1'b0;
      cfg_odd  <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
    end else if (start_det) begin
      cfg_baud <= BaudSel;
      cfg_par  <= ParEn;
      cfg_odd  <= ParOdd;
      perr     <= 1'b0;
    end else begin
      if (state == S_DATA && bit_sample) begin
        shreg[bit_idx] <= rxs;
      end
      if (state == S_PARITY && bit_sample) begin
        perr <= (rxs != ((^shreg) ^ cfg_odd));
      end
    end
  end

  // Start detection re-arms only once the line has been seen high, so a
  // frame ending with a low stop bit is not followed by spurious frames.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      armed <= 1'b0;
    end else if (commit && !rxs) begin
      armed <= 1'b0;
    end else if (rxs) begin
      armed <= 1'b1;
    end
  end

  // Output register and handshake. The stop-bit value is used directly as
  // the framing flag on the commit cycle.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      Dout     <= 8'h00;
      Ready    <= 1'b0;
      ParErr   <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else if (commit) begin
      Dout     <= shreg;
      ParErr   <= perr;
      FrameErr <= !rxs;
      Ready    <= 1'b1;
      Overrun  <= Ready && !Ack;
    end else if (Ack && Ready) begin
      Ready    <= 1'b0;
      Overrun  <= 1'b0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx with CLK_DIV0 = 16.
// At BaudSel = 0 one bit is 256 clocks; at BaudSel = 2 one bit is 64 clocks.
// Inputs are driven on the falling clock edge and outputs are checked there.

module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [2:0] baud_sel;
  logic       par_en;
  logic       par_odd;
  logic       ack;
  logic [7:0] dout;
  logic       ready;
  logic       par_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(.CLK_DIV0(16)) dut (
    .Clock     (clk),
    .Rst       (rst),
    .rx        (rx),
    .BaudSel   (baud_sel),
    .ParEn     (par_en),
    .ParOdd    (par_odd),
    .Ack       (ack),
    .Dout      (dout),
    .Ready     (ready),
    .ParErr    (par_err),
    .FrameErr  (frame_err),
    .Overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dout(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, dout}, {24'd0, e});
    end
  endtask

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int bclk);
    rx = b;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int bclk, input logic release_line);
    send_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) send_bit(d[i], bclk);
    if (pen) send_bit(pbit, bclk);
    send_bit(sbit, bclk);
    if (release_line) rx = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    //             data   pen   podd  pbit  stop  dout   perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h6E, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0};

    rst      = 1'b1;
    rx       = 1'b1;
    baud_sel = 3'd0;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    ack      = 1'b0;
    idle(3);

    // Reset values.
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_flags", {29'd0, par_err, frame_err, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(10);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table-driven frames at BaudSel = 0.
    for (int v = 0; v < 8; v++) begin
      par_en  = vecs[v].pen;
      par_odd = vecs[v].podd;
      exp_q.push_back(vecs[v].exp_dout);
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop, 256, 1'b1);
      idle(20);
      check($sformatf("v%0d_ready", v), {31'd0, ready}, 32'd1);
      check_dout($sformatf("v%0d_dout", v));
      check($sformatf("v%0d_parerr", v), {31'd0, par_err}, {31'd0, vecs[v].exp_perr});
      check($sformatf("v%0d_frameerr", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("v%0d_overrun", v), {31'd0, overrun}, 32'd0);
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      pulse_ack();
      check($sformatf("v%0d_ack_ready", v), {31'd0, ready}, 32'd0);
      idle(10);
    end

    // Framing error followed by a break (line held low).
    par_en = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 256, 1'b0);
    check("brk_ready", {31'd0, ready}, 32'd1);
    check_dout("brk_dout");
    check("brk_frameerr", {31'd0, frame_err}, 32'd1);
    pulse_ack();
    check("brk_ack_ready", {31'd0, ready}, 32'd0);
    idle(2000);
    check("brk_hold_ready", {31'd0, ready}, 32'd0);
    check("brk_hold_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle(30);
    check("brk_release_ready", {31'd0, ready}, 32'd0);

    // False start: 48-clock glitch.
    rx = 1'b0;
    idle(20);
    check("fs_busy_high", {31'd0, busy}, 32'd1);
    idle(28);
    rx = 1'b1;
    idle(300);
    check("fs_busy_low", {31'd0, busy}, 32'd0);
    check("fs_ready", {31'd0, ready}, 32'd0);

    // Overrun: two back-to-back frames without Ack.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 256, 1'b1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 256, 1'b1);
    idle(20);
    check("ovr_ready", {31'd0, ready}, 32'd1);
    check_dout("ovr_dout");
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    pulse_ack();
    check("ovr_ack_ready", {31'd0, ready}, 32'd0);
    check("ovr_ack_overrun", {31'd0, overrun}, 32'd0);
    idle(10);

    // Ack landing on the commit cycle (start edge + 2434 clocks).
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 256, 1'b1);
    check("col_pre_ready", {31'd0, ready}, 32'd1);
    exp_q.push_back(8'h44);
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1, 256, 1'b1);
      begin
        repeat (2434) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    idle(10);
    check("col_ready", {31'd0, ready}, 32'd1);
    check("col_overrun", {31'd0, overrun}, 32'd0);
    check_dout("col_dout");
    pulse_ack();
    idle(10);

    // Baud select 2 and reset mid-frame.
    baud_sel = 3'd2;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 64, 1'b1);
    idle(10);
    check("b2_ready", {31'd0, ready}, 32'd1);
    check_dout("b2_dout");

    send_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 64);
    send_bit(1'b1, 32);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_dout", {24'd0, dout}, 32'h00);
    check("mrst_ready", {31'd0, ready}, 32'd0);
    check("mrst_flags", {29'd0, par_err, frame_err, overrun}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 64, 1'b1);
    idle(10);
    check("post_ready", {31'd0, ready}, 32'd1);
    check_dout("post_dout");
    check("post_flags", {29'd0, par_err, frame_err, overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
